// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
// Sequencing controller for the PWM generator configuration inputs
// (pwm_en, functions, period, compare1, compare2).
// - New configurations arrive over a valid/ready handshake into shadow registers.
// - Shadow values are applied only at counter period boundaries (count_val == period).
// - compare1 ramps toward its target by one step per PWM period.
// - stop aborts to IDLE from any state and has priority over every other event.
// Optional build macro: PWM_CTRL_WDOG_EN
// - Adds a WDOG_W-bit watchdog over the ARM/RAMP states.
// - A watchdog expiry aborts like stop and sets a sticky fault flag.
// - Without the macro no watchdog is built and fault is tied low.

module pwm_ramp_ctrl #(
    parameter int CW     = 16,
    parameter int WDOG_W = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_period,
    input  logic [1:0]    cfg_mode,
    input  logic [CW-1:0] cfg_target,
    input  logic [CW-1:0] cfg_compare2,
    input  logic [CW-1:0] cfg_step,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] count_val,
    output logic          pwm_en,
    output logic [7:0]    functions,
    output logic [CW-1:0] period,
    output logic [CW-1:0] compare1,
    output logic [CW-1:0] compare2,
    output logic          busy,
    output logic          done,
    output logic          fault
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RAMP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Controller state and registered outputs
    state_t        state_r;
    logic          pending_r;
    logic          arm_from_hold_r;
    logic          pwm_en_r;
    logic [7:0]    functions_r;
    logic [CW-1:0] period_r;
    logic [CW-1:0] compare1_r;
    logic [CW-1:0] compare2_r;
    logic          busy_r;
    logic          done_r;

    // Shadow configuration, written only by an accepted handshake
    logic [CW-1:0] sh_period_r;
    logic [1:0]    sh_mode_r;
    logic [CW-1:0] sh_target_r;
    logic [CW-1:0] sh_compare2_r;
    logic [CW-1:0] sh_step_r;

    // Combinational decode
    logic          boundary_s;
    logic          cfg_ready_s;
    logic          accept_s;
    logic          abort_s;
    logic          trip_s;
    logic [CW-1:0] ramp_next_s;
    logic [CW-1:0] clamp_target_s;

    // One ramp step of cur toward tgt. The upward sum is formed one bit wider
    // so a large step can never wrap past the target; the downward path
    // compares the step against the remaining distance so it never borrows.
    // A zero step means jump straight to the target.
    function automatic logic [CW-1:0] ramp_step(
        input logic [CW-1:0] cur,
        input logic [CW-1:0] tgt,
        input logic [CW-1:0] stp
    );
        logic [CW:0]   sum;
        logic [CW-1:0] res;
        sum = {1'b0, cur} + {1'b0, stp};
        if (stp == {CW{1'b0}}) begin
            res = tgt;
        end else if (cur < tgt) begin
            if (sum >= {1'b0, tgt}) begin
                res = tgt;
            end else begin
                res = sum[CW-1:0];
            end
        end else if (cur > tgt) begin
            if (stp >= (cur - tgt)) begin
                res = tgt;
            end else begin
                res = cur - stp;
            end
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // Decode boundary, handshake acceptance, abort and the next ramp value
    always_comb begin
        boundary_s  = (count_val == period_r);
        cfg_ready_s = !pending_r && ((state_r == ST_IDLE) || (state_r == ST_HOLD));
        accept_s    = cfg_valid && cfg_ready_s && !stop;
        abort_s     = stop || trip_s;
        ramp_next_s = ramp_step(compare1_r, sh_target_r, sh_step_r);
        if (cfg_target > cfg_period) begin
            clamp_target_s = cfg_period;
        end else begin
            clamp_target_s = cfg_target;
        end
    end

    // Capture an accepted configuration; the target never exceeds its period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_period_r   <= {CW{1'b0}};
            sh_mode_r     <= 2'b00;
            sh_target_r   <= {CW{1'b0}};
            sh_compare2_r <= {CW{1'b0}};
            sh_step_r     <= {CW{1'b0}};
        end else if (accept_s) begin
            sh_period_r   <= cfg_period;
            sh_mode_r     <= cfg_mode;
            sh_target_r   <= clamp_target_s;
            sh_compare2_r <= cfg_compare2;
            sh_step_r     <= cfg_step;
        end
    end

    // Sequencing FSM: arm at a boundary, ramp once per period, abort on stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            pending_r       <= 1'b0;
            arm_from_hold_r <= 1'b0;
            pwm_en_r        <= 1'b0;
            functions_r     <= 8'h00;
            period_r        <= {CW{1'b0}};
            compare1_r      <= {CW{1'b0}};
            compare2_r      <= {CW{1'b0}};
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else if (abort_s) begin
            // period/compare values are left as they were; only the enable
            // and function bits are dropped, and a same-cycle cfg is ignored
            state_r         <= ST_IDLE;
            pending_r       <= 1'b0;
            arm_from_hold_r <= 1'b0;
            pwm_en_r        <= 1'b0;
            functions_r     <= 8'h00;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                pending_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    pwm_en_r    <= 1'b0;
                    functions_r <= 8'h00;
                    if (start && pending_r) begin
                        state_r         <= ST_ARM;
                        busy_r          <= 1'b1;
                        arm_from_hold_r <= 1'b0;
                    end
                end
                ST_ARM: begin
                    if (boundary_s) begin
                        period_r    <= sh_period_r;
                        functions_r <= {6'b000000, sh_mode_r};
                        compare2_r  <= sh_compare2_r;
                        pwm_en_r    <= 1'b1;
                        pending_r   <= 1'b0;
                        if (arm_from_hold_r) begin
                            // Running output: duty continues from where it is
                            if (compare1_r == sh_target_r) begin
                                state_r <= ST_HOLD;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= ST_RAMP;
                            end
                        end else begin
                            // Fresh start: soft-start from zero duty
                            compare1_r <= {CW{1'b0}};
                            if (sh_target_r == {CW{1'b0}}) begin
                                state_r <= ST_HOLD;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= ST_RAMP;
                            end
                        end
                    end
                end
                ST_RAMP: begin
                    if (boundary_s) begin
                        compare1_r <= ramp_next_s;
                        if (ramp_next_s == sh_target_r) begin
                            state_r <= ST_HOLD;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (pending_r) begin
                        state_r         <= ST_ARM;
                        busy_r          <= 1'b1;
                        arm_from_hold_r <= 1'b1;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    pending_r       <= 1'b0;
                    arm_from_hold_r <= 1'b0;
                    pwm_en_r        <= 1'b0;
                    functions_r     <= 8'h00;
                    busy_r          <= 1'b0;
                end
            endcase
        end
    end

`ifdef PWM_CTRL_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_ONE = WDOG_W'(1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = {WDOG_W{1'b1}};

    logic [WDOG_W-1:0] wdog_r;
    logic              fault_r;

    assign trip_s = busy_r && (wdog_r == WDOG_MAX);

    // Count cycles spent in ARM/RAMP since the last boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_r <= {WDOG_W{1'b0}};
        end else if (!busy_r || boundary_s || abort_s) begin
            wdog_r <= {WDOG_W{1'b0}};
        end else begin
            wdog_r <= wdog_r + WDOG_ONE;
        end
    end

    // Sticky fault: set on expiry, cleared by the next accepted configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_r <= 1'b0;
        end else if (trip_s) begin
            fault_r <= 1'b1;
        end else if (accept_s) begin
            fault_r <= 1'b0;
        end
    end

    assign fault = fault_r;
`else
    assign trip_s = 1'b0;
    assign fault  = 1'b0;

    // WDOG_W sizes the watchdog only; in this build it has no effect
    if (WDOG_W < 1) begin : g_wdog_w_unused
    end
`endif

    assign cfg_ready = cfg_ready_s;
    assign pwm_en    = pwm_en_r;
    assign functions = functions_r;
    assign period    = period_r;
    assign compare1  = compare1_r;
    assign compare2  = compare2_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed bench for pwm_ramp_ctrl with a cycle-level
// behavioural model compared against the DUT on every falling edge, plus
// hand-computed literal expectations for each scenario.

module tb_pwm_ramp_ctrl;

    localparam int CW     = 16;
    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_RAMP = 2;
    localparam int P_HOLD = 3;

    logic          clk;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_period;
    logic [1:0]    cfg_mode;
    logic [CW-1:0] cfg_target;
    logic [CW-1:0] cfg_compare2;
    logic [CW-1:0] cfg_step;
    logic          start;
    logic          stop;
    logic [CW-1:0] count_val;
    logic          pwm_en;
    logic [7:0]    functions;
    logic [CW-1:0] period;
    logic [CW-1:0] compare1;
    logic [CW-1:0] compare2;
    logic          busy;
    logic          done;
    logic          fault;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    // Model of the controller, in plain integers
    int m_phase, m_pending, m_from_hold, m_en, m_mode, m_period, m_c1, m_c2, m_done;
    int s_period, s_mode, s_target, s_c2, s_step;

    // Observation helpers fed by the compare process
    int c1_log[$];
    int last_c1       = 0;
    int done_cnt      = 0;
    int ready_in_busy = 0;

    pwm_ramp_ctrl #(.CW(CW), .WDOG_W(20)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_mode     (cfg_mode),
        .cfg_target   (cfg_target),
        .cfg_compare2 (cfg_compare2),
        .cfg_step     (cfg_step),
        .start        (start),
        .stop         (stop),
        .count_val    (count_val),
        .pwm_en       (pwm_en),
        .functions    (functions),
        .period       (period),
        .compare1     (compare1),
        .compare2     (compare2),
        .busy         (busy),
        .done         (done),
        .fault        (fault)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int model_ramp(input int cur, input int tgt, input int st);
        if (st == 0) return tgt;
        if (cur < tgt) return (cur + st > tgt) ? tgt : cur + st;
        if (cur > tgt) return (cur - st < tgt) ? tgt : cur - st;
        return cur;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_pending = 0; m_from_hold = 0; m_en = 0; m_mode = 0;
        m_period = 0; m_c1 = 0; m_c2 = 0; m_done = 0;
        s_period = 0; s_mode = 0; s_target = 0; s_c2 = 0; s_step = 0;
    endtask

    task automatic model_step();
        bit bnd;
        bit rdy;
        bit take;
        bnd  = (int'(count_val) == m_period);
        rdy  = (m_pending == 0) && (m_phase == P_IDLE || m_phase == P_HOLD);
        take = cfg_valid && rdy && !stop;
        m_done = 0;
        if (stop) begin
            m_phase = P_IDLE; m_en = 0; m_mode = 0; m_pending = 0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (start && m_pending != 0) begin
                        m_phase = P_ARM; m_from_hold = 0;
                    end
                end
                P_ARM: begin
                    if (bnd) begin
                        m_period = s_period; m_mode = s_mode; m_c2 = s_c2;
                        m_en = 1; m_pending = 0;
                        if (m_from_hold == 0) m_c1 = 0;
                        if (m_c1 == s_target) begin m_phase = P_HOLD; m_done = 1; end
                        else m_phase = P_RAMP;
                    end
                end
                P_RAMP: begin
                    if (bnd) begin
                        m_c1 = model_ramp(m_c1, s_target, s_step);
                        if (m_c1 == s_target) begin m_phase = P_HOLD; m_done = 1; end
                    end
                end
                default: begin
                    if (m_pending != 0) begin m_phase = P_ARM; m_from_hold = 1; end
                end
            endcase
            if (take) begin
                s_period = int'(cfg_period);
                s_mode   = int'(cfg_mode);
                s_target = (int'(cfg_target) > int'(cfg_period)) ? int'(cfg_period) : int'(cfg_target);
                s_c2     = int'(cfg_compare2);
                s_step   = int'(cfg_step);
                m_pending = 1;
            end
        end
    endtask

    // Advance the model on every rising edge
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Counter stimulus: counts 0..period like the real counter
    initial begin
        count_val = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || int'(count_val) >= m_period) count_val = '0;
            else count_val = count_val + 16'd1;
        end
    end

    // Compare DUT outputs against the model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                check("cfg_ready", {31'b0, cfg_ready},
                      (m_pending == 0 && (m_phase == P_IDLE || m_phase == P_HOLD)) ? 1 : 0);
                check("pwm_en",    {31'b0, pwm_en}, m_en);
                check("functions", {24'b0, functions}, m_mode);
                check("period",    {16'b0, period}, m_period);
                check("compare1",  {16'b0, compare1}, m_c1);
                check("compare2",  {16'b0, compare2}, m_c2);
                check("busy",      {31'b0, busy}, (m_phase == P_ARM || m_phase == P_RAMP) ? 1 : 0);
                check("done",      {31'b0, done}, m_done);
                check("fault",     {31'b0, fault}, 0);
                if (busy === 1'b1 && cfg_ready === 1'b1) ready_in_busy++;
                if (done === 1'b1) done_cnt++;
                if (int'(compare1) != last_c1) begin
                    c1_log.push_back(int'(compare1));
                    last_c1 = int'(compare1);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cfg(input int p, input int md, input int tg, input int c2, input int st);
        bit hs;
        hs = 0;
        cfg_period   = CW'(p);
        cfg_mode     = 2'(md);
        cfg_target   = CW'(tg);
        cfg_compare2 = CW'(c2);
        cfg_step     = CW'(st);
        cfg_valid    = 1'b1;
        for (int i = 0; i < 64 && !hs; i++) begin
            @(negedge clk);
            hs = cfg_ready;
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b0;
        check("cfg_handshake", {31'b0, hs}, 1);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int max);
        bit seen;
        seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        check(nm, {31'b0, seen}, 1);
        cyc(1);
    endtask

    task automatic check_log(input string nm, input int n,
                             input int e0, input int e1, input int e2, input int e3);
        int ex[4];
        ex = '{e0, e1, e2, e3};
        check({nm, "_len"}, c1_log.size(), n);
        for (int i = 0; i < n; i++) begin
            check(nm, (i < c1_log.size()) ? c1_log[i] : -1, ex[i]);
        end
    endtask

    // Directed scenarios
    initial begin
        int dc;
        bit mid;
        rst_n = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_period = '0; cfg_mode = 2'b00; cfg_target = '0; cfg_compare2 = '0; cfg_step = '0;
        #2 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        #17;
        // Reset state
        check("rst_pwm_en", {31'b0, pwm_en}, 0);
        check("rst_cfg_ready", {31'b0, cfg_ready}, 1);
        check("rst_compare1", {16'b0, compare1}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        #22 rst_n = 1'b1;
        cyc(2);

        // Soft-start ramp 0,30,60,90,100 at period 199
        send_cfg(199, 1, 100, 150, 30);
        check("t1_period_before_arm", {16'b0, period}, 0);
        c1_log.delete();
        start_pulse();
        check("t1_en_in_arm", {31'b0, pwm_en}, 0);
        check("t1_busy_in_arm", {31'b0, busy}, 1);
        cyc(1);
        check("t1_en_rise", {31'b0, pwm_en}, 1);
        check("t1_period_loaded", {16'b0, period}, 199);
        wait_done("t1_done", 3000);
        check("t1_compare1", {16'b0, compare1}, 100);
        check("t1_functions", {24'b0, functions}, 1);
        check("t1_compare2", {16'b0, compare2}, 150);
        check("t1_busy_hold", {31'b0, busy}, 0);
        check("t1_done_count", done_cnt, 1);
        check_log("t1_c1_seq", 4, 30, 60, 90, 100);

        // Ramp down from HOLD with borrow guard: 100,60,20,10
        c1_log.delete();
        send_cfg(149, 1, 10, 77, 40);
        check("t4_period_held", {16'b0, period}, 199);
        check("t4_compare2_held", {16'b0, compare2}, 150);
        wait_done("t4_done", 3000);
        check_log("t4_c1_seq", 3, 60, 20, 10, 0);
        check("t4_period", {16'b0, period}, 149);
        check("t4_compare2", {16'b0, compare2}, 77);
        check("t4_ready_in_busy", ready_in_busy, 0);

        // Step 0 from IDLE: jump 0 -> 50
        stop_pulse();
        check("t2_stop_en", {31'b0, pwm_en}, 0);
        check("t2_stop_functions", {24'b0, functions}, 0);
        send_cfg(63, 2, 50, 10, 0);
        c1_log.delete();
        start_pulse();
        wait_done("t2_done", 1000);
        check_log("t2_c1_seq", 2, 0, 50, 0, 0);
        check("t2_functions", {24'b0, functions}, 2);
        check("t2_period", {16'b0, period}, 63);

        // Target clamp: 500 stored as 99
        stop_pulse();
        send_cfg(99, 3, 500, 20, 40);
        c1_log.delete();
        start_pulse();
        wait_done("t3_done", 2000);
        check_log("t3_c1_seq", 4, 0, 40, 80, 99);
        cyc(250);
        check("t3_c1_settled", {16'b0, compare1}, 99);
        check("t3_busy", {31'b0, busy}, 0);
        check("t3_pwm_en", {31'b0, pwm_en}, 1);

        // stop mid-RAMP together with cfg_valid
        stop_pulse();
        send_cfg(99, 1, 90, 30, 10);
        start_pulse();
        mid = 0;
        for (int i = 0; i < 1000 && !mid; i++) begin
            @(negedge clk);
            if (busy === 1'b1 && pwm_en === 1'b1 && compare1 >= 16'd20 && compare1 < 16'd90) mid = 1;
        end
        check("t5_mid_ramp", {31'b0, mid}, 1);
        @(posedge clk);
        #1;
        dc = done_cnt;
        cfg_period = 16'd5; cfg_mode = 2'd3; cfg_target = 16'd3; cfg_compare2 = 16'd2; cfg_step = 16'd1;
        stop = 1'b1; cfg_valid = 1'b1;
        cyc(1);
        stop = 1'b0; cfg_valid = 1'b0;
        check("t5_pwm_en", {31'b0, pwm_en}, 0);
        check("t5_functions", {24'b0, functions}, 0);
        check("t5_busy", {31'b0, busy}, 0);
        check("t5_ready", {31'b0, cfg_ready}, 1);
        cyc(300);
        check("t5_no_done", done_cnt, dc);

        // stop with an acceptable handshake in IDLE discards it
        cfg_period = 16'd40; cfg_mode = 2'd1; cfg_target = 16'd5; cfg_compare2 = 16'd5; cfg_step = 16'd1;
        stop = 1'b1; cfg_valid = 1'b1;
        cyc(1);
        stop = 1'b0; cfg_valid = 1'b0;
        check("t6_not_pending", {31'b0, cfg_ready}, 1);
        start_pulse();
        cyc(5);
        check("t6_busy", {31'b0, busy}, 0);
        check("t6_pwm_en", {31'b0, pwm_en}, 0);

        check("total_done_count", done_cnt, 4);
        check("fault_low", {31'b0, fault}, 0);
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
